// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbiter for the register-file write port (ALU, load,
//             mult/div) with a drain-then-halt sequencer feeding the dump.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int HALT_DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_num,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic [4:0]  rd_num,
  output logic [31:0] rd_data,
  output logic        rd_we,
  input  logic        halt_req,
  output logic        halted,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [7:0] c_drain_max = 8'(HALT_DRAIN_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [4:0]  r_rd_num;
  logic [31:0] r_rd_data;
  logic        r_rd_we;
  logic        r_halted;
  logic        r_drain_timeout;
  logic        w_timeout_set;

  logic [1:0]  w_ptr_eff;
  logic [2:0]  w_cand;
  logic        w_arb_en;
  logic        w_grant_vld;
  logic [1:0]  w_grant_idx;
  logic        w_grant;
  logic [4:0]  w_sel_num;
  logic [31:0] w_sel_data;

  // An out-of-range pointer value behaves as requester 0.
  assign w_ptr_eff = (r_ptr == 2'd3) ? 2'd0 : r_ptr;
  assign w_arb_en  = rst_b && (r_state != ST_HALTED);

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = 2'd0;
    w_cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      w_cand = {1'b0, w_ptr_eff} + 3'(k);
      if (w_cand >= 3'd3) w_cand = w_cand - 3'd3;
      if (!w_grant_vld && req_valid[w_cand[1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[1:0];
      end
    end
  end

  assign w_grant    = w_grant_vld && w_arb_en;
  assign req_ready  = w_grant ? (3'b001 << w_grant_idx) : 3'b000;
  assign w_sel_num  = req_num[5*w_grant_idx +: 5];
  assign w_sel_data = req_data[32*w_grant_idx +: 32];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt_req) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_DRAIN: begin
        // Completion wins over timeout when both hold.
        if ((req_valid == 3'b000) && !r_rd_we) begin
          w_state_nxt = ST_HALTED;
        end else if (r_cnt == c_drain_max) begin
          w_state_nxt   = ST_HALTED;
          w_timeout_set = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state         <= ST_RUN;
      r_ptr           <= 2'd0;
      r_cnt           <= 8'd0;
      r_rd_we         <= 1'b0;
      r_rd_num        <= 5'd0;
      r_rd_data       <= 32'd0;
      r_halted        <= 1'b0;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_halted        <= r_halted || (w_state_nxt == ST_HALTED);
      r_drain_timeout <= r_drain_timeout || w_timeout_set;
      if (w_grant) begin
        r_ptr     <= (w_grant_idx == 2'd2) ? 2'd0 : w_grant_idx + 2'd1;
        r_rd_num  <= w_sel_num;
        r_rd_data <= w_sel_data;
        // Writes to r0 are consumed but never committed.
        r_rd_we   <= (w_sel_num != 5'd0);
      end else begin
        r_rd_we <= 1'b0;
      end
    end
  end

  assign rd_num        = r_rd_num;
  assign rd_data       = r_rd_data;
  assign rd_we         = r_rd_we;
  assign halted        = r_halted;
  assign drain_timeout = r_drain_timeout;

endmodule
`default_nettype wire
